// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard detection, EX/MEM forwarding,
// bubble insertion and a saturating stall counter.
module id_ex_stage #(
  parameter int CTRL_W = 12
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [31:0]       IfIdInstr,
  input  logic [31:0]       IfIdPCPlus4,
  input  logic              IfIdValid,
  input  logic [31:0]       ReadData1,
  input  logic [31:0]       ReadData2,
  input  logic              CtrlMemRead,
  input  logic              CtrlRegWrite,
  input  logic [CTRL_W-1:0] CtrlMisc,
  input  logic [4:0]        CtrlRegDst,
  input  logic              ExMemRegWrite,
  input  logic              ExMemMemRead,
  input  logic [4:0]        ExMemWriteRegister,
  input  logic [31:0]       ExMemALUResult,
  input  logic              Flush,
  output logic              Stall,
  output logic              IdExValid,
  output logic              IdExMemRead,
  output logic              IdExRegWrite,
  output logic [CTRL_W-1:0] IdExCtrl,
  output logic [31:0]       IdExRsData,
  output logic [31:0]       IdExRtData,
  output logic [31:0]       IdExImm,
  output logic [4:0]        IdExRs,
  output logic [4:0]        IdExRt,
  output logic [4:0]        IdExWriteRegister,
  output logic [31:0]       IdExPCPlus4,
  output logic [15:0]       StallCount
);

  logic [5:0]        w_op;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic              w_rt_used;
  logic              w_zext;
  logic [4:0]        w_src1;
  logic [4:0]        w_src2;
  logic              w_stall;
  logic              w_bubble;
  logic [31:0]       w_imm;
  logic [31:0]       w_op1;
  logic [31:0]       w_op2;

  logic              r_valid;
  logic              r_memread;
  logic              r_regwrite;
  logic [CTRL_W-1:0] r_ctrl;
  logic [31:0]       r_rs_data;
  logic [31:0]       r_rt_data;
  logic [31:0]       r_imm;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_wr;
  logic [31:0]       r_pc4;
  logic [15:0]       r_cnt;

  assign w_op = IfIdInstr[31:26];
  assign w_rs = IfIdInstr[25:21];
  assign w_rt = IfIdInstr[20:16];

  // Opcode classes: which ops read rt, which zero-extend the immediate
  always_comb begin
    w_rt_used = 1'b0;
    w_zext    = 1'b0;
    unique case (w_op)
      6'h00, 6'h04, 6'h05,
      6'h28, 6'h29, 6'h2B: w_rt_used = 1'b1;
      6'h0C, 6'h0D, 6'h0E: w_zext    = 1'b1;
      default: ;
    endcase
  end

  assign w_src1 = w_rs;
  assign w_src2 = w_rt_used ? w_rt : 5'd0;

  function automatic logic f_haz(input logic [4:0] s);
    logic ex_hit;
    logic ld_hit;
    ex_hit = r_valid && r_regwrite && (r_wr == s);
    ld_hit = ExMemRegWrite && ExMemMemRead &&
             (ExMemWriteRegister == s);
    return (s != 5'd0) && (ex_hit || ld_hit);
  endfunction

  function automatic logic [31:0] f_opnd(
    input logic [4:0]  s,
    input logic [31:0] rd
  );
    logic fwd;
    fwd = ExMemRegWrite && !ExMemMemRead &&
          (ExMemWriteRegister == s);
    if (s == 5'd0)
      return 32'd0;
    else if (fwd)
      return ExMemALUResult;
    else
      return rd;
  endfunction

  assign w_stall  = Rst_n && IfIdValid &&
                    (f_haz(w_src1) || f_haz(w_src2));
  assign w_bubble = Flush || w_stall;
  assign w_op1    = f_opnd(w_src1, ReadData1);
  assign w_op2    = f_opnd(w_src2, ReadData2);
  assign w_imm    = w_zext ? {16'd0, IfIdInstr[15:0]}
                           : {{16{IfIdInstr[15]}}, IfIdInstr[15:0]};

  // ID/EX register: flush or stall inserts a fully zeroed bubble
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_valid    <= 1'b0;
      r_memread  <= 1'b0;
      r_regwrite <= 1'b0;
      r_ctrl     <= '0;
      r_rs_data  <= 32'd0;
      r_rt_data  <= 32'd0;
      r_imm      <= 32'd0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_wr       <= 5'd0;
      r_pc4      <= 32'd0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_memread  <= 1'b0;
      r_regwrite <= 1'b0;
      r_ctrl     <= '0;
      r_rs_data  <= 32'd0;
      r_rt_data  <= 32'd0;
      r_imm      <= 32'd0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_wr       <= 5'd0;
      r_pc4      <= 32'd0;
    end else begin
      r_valid    <= IfIdValid;
      r_memread  <= IfIdValid && CtrlMemRead;
      r_regwrite <= IfIdValid && CtrlRegWrite;
      r_ctrl     <= IfIdValid ? CtrlMisc : '0;
      r_rs_data  <= w_op1;
      r_rt_data  <= w_op2;
      r_imm      <= w_imm;
      r_rs       <= w_rs;
      r_rt       <= w_rt;
      r_wr       <= CtrlRegDst;
      r_pc4      <= IfIdPCPlus4;
    end
  end

  // Saturating count of stall cycles that were not overridden by a flush
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      r_cnt <= 16'd0;
    else if (w_stall && !Flush && (r_cnt != 16'hFFFF))
      r_cnt <= r_cnt + 16'd1;
  end

  assign Stall             = w_stall;
  assign IdExValid         = r_valid;
  assign IdExMemRead       = r_memread;
  assign IdExRegWrite      = r_regwrite;
  assign IdExCtrl          = r_ctrl;
  assign IdExRsData        = r_rs_data;
  assign IdExRtData        = r_rt_data;
  assign IdExImm           = r_imm;
  assign IdExRs            = r_rs;
  assign IdExRt            = r_rt;
  assign IdExWriteRegister = r_wr;
  assign IdExPCPlus4       = r_pc4;
  assign StallCount        = r_cnt;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the MIPS datapath. It sits directly downstream of the register file, which captures read data on the falling clock edge. On each rising edge it latches the decoded instruction fields, the two register operands and the pass-through control bits into the ID/EX pipeline register. It forwards ALU results from EX/MEM, detects RAW hazards against in-flight producers, stalls the front end and inserts bubbles.

## Interface
Parameters:
- CTRL_W, 12, width of pass-through control bundle (excluding MemRead/RegWrite)

Ports:
- Clk  in  1  clock; ID/EX register updates on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- IfIdInstr  in  32  instruction held in IF/ID
- IfIdPCPlus4  in  32  PC+4 of that instruction
- IfIdValid  in  1  IF/ID holds a real instruction
- ReadData1, ReadData2  in  32  register-file outputs for rs/rt (negedge-registered, stable at rising edge)
- CtrlMemRead, CtrlRegWrite  in  1  decoded load / register-write flags for IfIdInstr
- CtrlMisc  in  CTRL_W  remaining decoded control, passed through
- CtrlRegDst  in  5  decoded destination register number
- ExMemRegWrite  in  1  EX/MEM instruction writes a register
- ExMemMemRead  in  1  EX/MEM instruction is a load
- ExMemWriteRegister  in  5  EX/MEM destination
- ExMemALUResult  in  32  EX/MEM ALU result
- Flush  in  1  taken branch/jump; kill instruction entering ID/EX
- Stall  out  1  combinational; hold PC and IF/ID
- IdExValid, IdExMemRead, IdExRegWrite  out  1  registered
- IdExCtrl  out  CTRL_W  registered control
- IdExRsData, IdExRtData  out  32  resolved operands
- IdExImm  out  32  extended immediate
- IdExRs, IdExRt, IdExWriteRegister  out  5
- IdExPCPlus4  out  32
- StallCount  out  16  saturating count of stall cycles

## Operation
- Fields: rs=IfIdInstr[25:21], rt=[20:16], op=[31:26].
- rt is a source only for op 0x00, 0x04, 0x05, 0x28, 0x29, 0x2B; otherwise rt matching is ignored.
- A source register is zero when it is register 0 or when the instruction does not use it; zero sources never hazard and never forward.
- Hazard (Stall=1) when IfIdValid and a non-zero source register matches either of the following. Conditions are evaluated fresh each cycle from pipeline contents; no hidden state beyond the ID/EX register.
  - (a) IdExValid && IdExRegWrite && IdExWriteRegister. Any producer in EX costs one stall.
  - (b) ExMemRegWrite && ExMemMemRead && ExMemWriteRegister. A load in MEM costs a second stall.
- Net stall counts: an ALU producer at distance 1 costs 1 stall; a load at distance 1 costs 2 stalls; a load at distance 2 costs 1 stall.
- Forwarding applies when there is no stall. For each source, if ExMemRegWrite && !ExMemMemRead && ExMemWriteRegister == source (non-zero), the operand is ExMemALUResult. Otherwise it is ReadData.
- WB-stage producers need no forwarding: the register file writes on the rising edge and reads on the falling edge of the same cycle.
- A source of register 0 forces operand data to 0, regardless of register contents.
- Immediate: zero-extend for op 0x0C/0x0D/0x0E; sign-extend otherwise.
- Rising-edge update, in priority order:
  - Flush: bubble.
  - Else Stall: bubble.
  - Else: load all fields. IdExValid=IfIdValid; IdExMemRead/RegWrite/Ctrl are gated by IfIdValid.
- Bubble: IdExValid, IdExMemRead, IdExRegWrite, IdExCtrl = 0. Data and register-number fields may hold any value, but must be zeroed for determinism.
- StallCount increments on every rising edge where Stall=1 and Flush=0, and saturates at 0xFFFF.

## Timing
- Reset (Rst_n low, asynchronous): every registered output is 0 and StallCount is 0.
- Stall is combinational from IF/ID, ID/EX and EX/MEM state; it is 0 while in reset.
- Latency: one cycle from IF/ID to ID/EX.
- Flush and Stall together: bubble inserted, Stall still asserted, StallCount not incremented.
- Reset released mid-stall: the pipeline restarts empty with no pending hazard.

## Test plan
- ALU back-to-back: add $8,$9,$10 (result 0x5) then sub $11,$8,$9 -> Stall=1 for 1 cycle with one bubble; sub then captures IdExRsData=0x5 via EX/MEM forwarding.
- Load-use: lw $8 then add $9,$8,$8 -> Stall=1 for exactly 2 cycles; add enters ID/EX with ReadData1 = the loaded value written in WB; StallCount=2.
- Register 0: add $0 result in EX followed by or $9,$0,$0 -> no stall; IdExRsData=IdExRtData=0 even when ReadData1=0xDEADBEEF.
- Store/immediate: ori $8,$0,0xFFFF -> no rt hazard; IdExImm=0x0000FFFF. addi with 0xFFFF -> IdExImm=0xFFFFFFFF.
- Flush during load-use stall -> next edge IdExValid=0 and StallCount unchanged; Rst_n pulse mid-stall -> all outputs 0 immediately, before any clock edge.
